uart_fifo_tx: RTL and testbench

//  Read-side consumer of the sample queue: pops words from the FIFO (first-word

---
 rtl/vdas_pkg.sv | 15 +
 rtl/baud_gen.sv | 31 +++
 rtl/uart_fifo_tx.sv | 128 ++++++++++++
 tb/tb_uart_fifo_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdas_pkg.sv
// Shared definitions for the acquisition path: UART FSM state encoding and
// the default bit period used by the queue drain and the future receiver.
package vdas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/baud_gen.sv
// Bit-period down-counter: bit_tick marks the last cycle of every bit.
// restart aligns the next bit period to the following clock edge.
module baud_gen
    import vdas_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic ck,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_fifo_tx.sv
// Drains the sample queue and serialises each popped word as a UART frame
// (start, NBITS data LSB first, STOP_BITS stop) on a registered tx line.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line high, waiting for en and a non-empty queue
// ST_START | start bit (tx low), word already latched in shift register
// ST_DATA  | data bits, one per bit period, LSB first
// ST_STOP  | stop bit(s), tx high; may pop the next word on the last cycle
module uart_fifo_tx
    import vdas_pkg::*;
#(
    parameter int NBITS        = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             q_em,
    input  logic [NBITS-1:0] q_data,
    output logic             q_pp,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t        state, state_nx;
    logic [NBITS-1:0] sh, sh_nx;
    logic [BW-1:0]    bit_idx, bit_nx;
    logic             stop_cnt, stop_nx;
    logic             tx_nx;
    logic             bit_tick;

    // a pop always begins a fresh bit period for the start bit
    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .ck      (ck),
        .rst_n   (rst_n),
        .restart (q_pp),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sh       <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nx;
            sh       <= sh_nx;
            bit_idx  <= bit_nx;
            stop_cnt <= stop_nx;
            tx       <= tx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        bit_nx     = bit_idx;
        stop_nx    = stop_cnt;
        tx_nx      = tx;
        q_pp       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_nx = 1'b1;
                if (en && !q_em) begin
                    q_pp     = 1'b1;
                    sh_nx    = q_data;
                    tx_nx    = 1'b0;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_nx    = sh[0];
                    sh_nx    = sh >> 1;
                    bit_nx   = '0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_nx    = 1'b1;
                        stop_nx  = 1'b0;
                        state_nx = ST_STOP;
                    end else begin
                        tx_nx  = sh[0];
                        sh_nx  = sh >> 1;
                        bit_nx = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        // chain straight into the next frame when possible
                        if (en && !q_em) begin
                            q_pp     = 1'b1;
                            sh_nx    = q_data;
                            tx_nx    = 1'b0;
                            state_nx = ST_START;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        stop_nx = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: two instances (1 and 2 stop bits) fed by queue models;
// a negedge monitor decodes tx frames and scores them against expected words.
module tb_uart_fifo_tx;

    localparam int CPB = 4;

    logic       ck;
    logic       rst_n;
    logic       en0, en1;
    logic       q_em0, q_em1;
    logic [7:0] q_data0, q_data1;
    logic [1:0] q_pp_w, tx_w, busy_w, fd_w;

    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    int total = 0;
    int bad   = 0;
    int pops0 = 0;
    int pops1 = 0;

    uart_fifo_tx #(.NBITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .ck(ck), .rst_n(rst_n), .en(en0), .q_em(q_em0), .q_data(q_data0),
        .q_pp(q_pp_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0])
    );

    uart_fifo_tx #(.NBITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .ck(ck), .rst_n(rst_n), .en(en1), .q_em(q_em1), .q_data(q_data1),
        .q_pp(q_pp_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1])
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic upd();
        q_em0   = (fifo0.size() == 0);
        q_data0 = q_em0 ? 8'hEE : fifo0[0];
        q_em1   = (fifo1.size() == 0);
        q_data1 = q_em1 ? 8'hEE : fifo1[0];
    endtask

    task automatic push0(input logic [7:0] w);
        fifo0.push_back(w);
        exp0.push_back(w);
        upd();
    endtask

    // one clock: pop strobes are sampled mid-cycle and applied just after the edge
    task automatic step();
        logic       p0, p1;
        logic [7:0] tmp;
        @(negedge ck);
        p0 = q_pp_w[0] && rst_n;
        p1 = q_pp_w[1] && rst_n;
        @(posedge ck);
        #1;
        if (p0) begin
            chk("pop0_nonempty", int'(fifo0.size() > 0), 1);
            if (fifo0.size() > 0) begin tmp = fifo0.pop_front(); pops0++; end
        end
        if (p1) begin
            chk("pop1_nonempty", int'(fifo1.size() > 0), 1);
            if (fifo1.size() > 0) begin tmp = fifo1.pop_front(); pops1++; end
        end
        upd();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_frm[2];
    int         pos[2];
    bit         shape_ok[2];
    bit         fd_ok[2];
    logic [7:0] rx[2];

    function automatic int flen(input int ch);
        return (ch == 0) ? CPB * 10 : CPB * 11;
    endfunction

    task automatic mon_bit(input int ch);
        int         p, b;
        logic [7:0] w;
        p = pos[ch];
        if (fd_w[ch] !== (p == flen(ch) - 1)) fd_ok[ch] = 1'b0;
        if (p < CPB) begin
            if (tx_w[ch] !== 1'b0) shape_ok[ch] = 1'b0;
        end else if (p < CPB * 9) begin
            b = (p - CPB) / CPB;
            if ((p - CPB) % CPB == 0) rx[ch][b] = tx_w[ch];
            else if (rx[ch][b] !== tx_w[ch]) shape_ok[ch] = 1'b0;
        end else if (tx_w[ch] !== 1'b1) begin
            shape_ok[ch] = 1'b0;
        end
        if (p == flen(ch) - 1) begin
            chk(ch == 0 ? "frame_shape0" : "frame_shape1", int'(shape_ok[ch]), 1);
            chk(ch == 0 ? "frame_done_pos0" : "frame_done_pos1", int'(fd_ok[ch]), 1);
            if (ch == 0 && exp0.size() > 0) begin
                w = exp0.pop_front();
                chk("byte0", int'(rx[ch]), int'(w));
            end else if (ch == 1 && exp1.size() > 0) begin
                w = exp1.pop_front();
                chk("byte1", int'(rx[ch]), int'(w));
            end else begin
                total++;
                bad++;
                $display("FAIL unexpected_frame ch%0d: got byte %02h want none", ch, rx[ch]);
            end
            in_frm[ch] = 1'b0;
        end
    endtask

    always @(negedge ck) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (!rst_n) begin
                in_frm[ch] = 1'b0;
            end else if (!in_frm[ch]) begin
                if (tx_w[ch] == 1'b0) begin
                    in_frm[ch]   = 1'b1;
                    pos[ch]      = 0;
                    shape_ok[ch] = 1'b1;
                    fd_ok[ch]    = 1'b1;
                    rx[ch]       = '0;
                end else begin
                    chk("idle_frame_done", int'(fd_w[ch]), 0);
                end
            end else begin
                pos[ch]++;
            end
            if (rst_n && in_frm[ch]) mon_bit(ch);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, cnt, base;
        rst_n = 1'b0;
        en0   = 1'b0;
        en1   = 1'b0;
        upd();
        steps(3);
        rst_n = 1'b1;
        step();
        chk("rst_tx", int'(tx_w[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_frame_done", int'(fd_w[0]), 0);
        chk("rst_q_pp", int'(q_pp_w[0]), 0);

        // idle with empty queue
        en0 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_tx", int'(tx_w[0]), 1);
            chk("idle_busy", int'(busy_w[0]), 0);
        end
        chk("idle_pops", pops0, 0);

        // single word, frame_done 40 cycles after the pop edge
        push0(8'hA5);
        step();
        n = 1;
        while (!fd_w[0] && n < 60) begin step(); n++; end
        chk("single_fd_latency", n, 40);
        steps(5);
        chk("single_pops", pops0, 1);
        chk("single_q_em", int'(q_em0), 1);
        chk("single_busy_after", int'(busy_w[0]), 0);

        // burst of three, contiguous frames
        base = pops0;
        push0(8'h00);
        push0(8'hFF);
        push0(8'h3C);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busy_w[0]) cnt++;
            else break;
        end
        chk("burst_busy_cycles", cnt, 120);
        chk("burst_pops", pops0 - base, 3);
        steps(5);

        // enable dropped during the first frame's data phase
        base = pops0;
        push0(8'h11);
        push0(8'h22);
        step();
        steps(12);
        en0 = 1'b0;
        steps(35);
        chk("gate_pops", pops0 - base, 1);
        chk("gate_q_em", int'(q_em0), 0);
        chk("gate_busy", int'(busy_w[0]), 0);
        steps(10);
        chk("gate_pops_hold", pops0 - base, 1);
        en0 = 1'b1;
        step();
        chk("gate_restart_pop", pops0 - base, 2);
        steps(45);

        // reset during data bit 3: in-flight word is lost
        push0(8'h5A);
        push0(8'hC3);
        push0(8'h96);
        step();
        steps(17);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", int'(tx_w[0]), 1);
        chk("midrst_busy", int'(busy_w[0]), 0);
        void'(exp0.pop_front());
        steps(2);
        rst_n = 1'b1;
        steps(90);
        chk("midrst_q_em", int'(q_em0), 1);
        chk("midrst_busy_after", int'(busy_w[0]), 0);

        // two stop bits: 44-cycle frame
        fifo1.push_back(8'h55);
        exp1.push_back(8'h55);
        upd();
        en1 = 1'b1;
        step();
        n = 1;
        while (!fd_w[1] && n < 80) begin step(); n++; end
        chk("stop2_fd_latency", n, 44);
        steps(10);
        chk("stop2_pops", pops1, 1);
        chk("stop2_busy_after", int'(busy_w[1]), 0);

        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
